key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 138 +++++++++++++
 tb/tb_key_conditioner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Conditions the multiplier front-panel inputs: synchronizes switches and keys,
// debounces both keys and turns press edges into single-cycle strobes gated by a small FSM.
module key_conditioner #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_n,
  input  logic       ClearA_LoadB_n,
  input  logic [7:0] SW,
  input  logic       Done,
  output logic [7:0] SW_sync,
  output logic       Run_pulse,
  output logic       LoadB_pulse,
  output logic       Busy
);

  localparam int unsigned   CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);
  localparam int            RUN     = 0;
  localparam int            LOAD    = 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_RELEASE
  } state_t;

  logic [7:0]    swMeta_q;
  logic [7:0]    swSync_q;
  logic [1:0]    keyRaw;
  logic [1:0]    keyMeta_q;
  logic [1:0]    keySync_q;
  logic [1:0]    deb_q;
  logic [1:0]    deb_d;
  logic [1:0]    debPrev_q;
  logic [1:0]    pressEdge;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  state_t        state_q;
  logic          runPulse_q;
  logic          loadPulse_q;
  logic          busy_q;

  assign keyRaw = {ClearA_LoadB_n, Run_n};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      swMeta_q  <= 8'h00;
      swSync_q  <= 8'h00;
      keyMeta_q <= 2'b11;
      keySync_q <= 2'b11;
    end else begin
      swMeta_q  <= SW;
      swSync_q  <= swMeta_q;
      keyMeta_q <= keyRaw;
      keySync_q <= keyMeta_q;
    end
  end

  // The counter is allowed to sit at DB_CYCLES for one cycle before the level
  // is taken, which gives the DB_CYCLES+3 raw-edge-to-strobe latency.
  always_comb begin
    deb_d = deb_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (keySync_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          deb_d[k] = keySync_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      deb_q     <= 2'b11;
      debPrev_q <= 2'b11;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      deb_q     <= deb_d;
      debPrev_q <= deb_q;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

  assign pressEdge = debPrev_q & ~deb_q;

  // Done is ignored while Run_pulse is still high so a stale Done from the
  // previous operation cannot end the new one.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      runPulse_q  <= 1'b0;
      loadPulse_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      runPulse_q  <= 1'b0;
      loadPulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressEdge[LOAD]) begin
            loadPulse_q <= 1'b1;
          end else if (pressEdge[RUN]) begin
            runPulse_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (Done && !runPulse_q) begin
            busy_q  <= 1'b0;
            state_q <= deb_q[RUN] ? IDLE : WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (deb_q[RUN]) begin
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SW_sync     = swSync_q;
  assign Run_pulse   = runPulse_q;
  assign LoadB_pulse = loadPulse_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key/Done
// traffic, all checked every cycle against a sample-window reference model.
module tb_key_conditioner;

  localparam int DB   = 16;
  localparam int HMAX = 16384;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run_n = 1'b1;
  logic       ClearA_LoadB_n = 1'b1;
  logic [7:0] SW = 8'h00;
  logic       Done = 1'b0;
  logic [7:0] SW_sync;
  logic       Run_pulse;
  logic       LoadB_pulse;
  logic       Busy;

  key_conditioner #(.DB_CYCLES(DB)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Run_n         (Run_n),
    .ClearA_LoadB_n(ClearA_LoadB_n),
    .SW            (SW),
    .Done          (Done),
    .SW_sync       (SW_sync),
    .Run_pulse     (Run_pulse),
    .LoadB_pulse   (LoadB_pulse),
    .Busy          (Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef enum {M_IDLE, M_BUSY, M_WAIT} mode_t;
  mode_t      mode;
  bit         mDeb [2];
  bit         pend [2];
  bit         hist [2][HMAX];
  logic [7:0] swD1;
  logic [7:0] expSw;
  bit         expRun;
  bit         expLoad;
  bit         expBusy;
  int         n;
  int         cntRun;
  int         cntLoad;
  int         firstRun;
  int         firstLoad;

  function automatic bit sampleAt(int k, int i);
    if (i < 0) return 1'b1;
    return hist[k][i];
  endfunction

  // A key level is accepted once the last DB+1 synchronized samples (raw
  // samples two edges old) all disagree with the current debounced level.
  function automatic bit windowAll(int k, int e, bit lvl);
    for (int i = e - DB - 2; i <= e - 2; i++) begin
      if (sampleAt(k, i) != lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelReset();
    mode    = M_IDLE;
    mDeb[0] = 1'b1;
    mDeb[1] = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    swD1    = 8'h00;
    expSw   = 8'h00;
    expRun  = 1'b0;
    expLoad = 1'b0;
    expBusy = 1'b0;
    n       = 0;
  endtask

  task automatic modelStep();
    bit runE;
    bit loadE;
    runE  = 1'b0;
    loadE = 1'b0;
    case (mode)
      M_IDLE: begin
        if (pend[1]) loadE = 1'b1;
        else if (pend[0]) begin
          runE = 1'b1;
          mode = M_BUSY;
        end
      end
      M_BUSY: if (Done && !expRun) mode = mDeb[0] ? M_IDLE : M_WAIT;
      M_WAIT: if (mDeb[0]) mode = M_IDLE;
      default: mode = M_IDLE;
    endcase
    expRun  = runE;
    expLoad = loadE;
    expBusy = (mode == M_BUSY);
    if (n >= HMAX) begin
      $display("[TB] FAIL history: got %0d expected below %0d", n, HMAX);
      $fatal(1, "[TB] history overflow");
    end
    hist[0][n] = Run_n;
    hist[1][n] = ClearA_LoadB_n;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0;
      if (windowAll(k, n, !mDeb[k])) begin
        mDeb[k] = !mDeb[k];
        pend[k] = !mDeb[k];
      end
    end
    expSw = swD1;
    swD1  = SW;
    n++;
  endtask

  task automatic clearCounts();
    cntRun    = 0;
    cntLoad   = 0;
    firstRun  = -1;
    firstLoad = -1;
  endtask

  task automatic cycle();
    @(posedge Clk);
    modelStep();
    #1;
    checkOutput("sw_sync", 32'(SW_sync), 32'(expSw));
    checkOutput("run_pulse", 32'(Run_pulse), 32'(expRun));
    checkOutput("loadb_pulse", 32'(LoadB_pulse), 32'(expLoad));
    checkOutput("busy", 32'(Busy), 32'(expBusy));
    if (Run_pulse) begin
      if (firstRun < 0) firstRun = n - 1;
      cntRun++;
    end
    if (LoadB_pulse) begin
      if (firstLoad < 0) firstLoad = n - 1;
      cntLoad++;
    end
  endtask

  // Reset is asserted and released one time unit after an edge so the first
  // post-reset edge is unambiguous; outputs must clear without any clock.
  task automatic applyReset(input logic [7:0] sw, input logic runLvl, input logic loadLvl);
    Reset = 1'b0;
    SW    = sw;
    Done  = 1'b0;
    #1;
    checkOutput("rst_run", 32'(Run_pulse), 32'd0);
    checkOutput("rst_load", 32'(LoadB_pulse), 32'd0);
    checkOutput("rst_busy", 32'(Busy), 32'd0);
    checkOutput("rst_sw", 32'(SW_sync), 32'd0);
    repeat (2) begin
      @(posedge Clk);
      #1;
      checkOutput("rst_hold_pulses", 32'({Run_pulse, LoadB_pulse, Busy}), 32'd0);
      checkOutput("rst_hold_sw", 32'(SW_sync), 32'd0);
    end
    Run_n          = runLvl;
    ClearA_LoadB_n = loadLvl;
    modelReset();
    Reset = 1'b1;
  endtask

  task automatic applyStimulus(input int cycles);
    int holdRun;
    int holdLoad;
    holdRun  = 0;
    holdLoad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (holdRun == 0) begin
        Run_n   = 1'($urandom_range(0, 1));
        holdRun = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB)) : int'($urandom_range(DB, 3 * DB));
      end
      if (holdLoad == 0) begin
        ClearA_LoadB_n = 1'($urandom_range(0, 1));
        holdLoad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB)) : int'($urandom_range(DB, 3 * DB));
      end
      holdRun--;
      holdLoad--;
      Done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) SW = 8'($urandom);
      cycle();
    end
  endtask

  initial begin
    modelReset();
    clearCounts();
    #1;
    applyReset(8'hF9, 1'b1, 1'b1);
    cycle();
    checkOutput("swsync_edge1", 32'(SW_sync), 32'h00);
    cycle();
    checkOutput("swsync_edge2", 32'(SW_sync), 32'hF9);
    repeat (5) cycle();

    applyReset(8'h00, 1'b1, 1'b0);
    clearCounts();
    repeat (40) cycle();
    checkOutput("loadb_latency", 32'(firstLoad), 32'd19);
    checkOutput("loadb_count", 32'(cntLoad), 32'd1);
    checkOutput("loadb_no_run", 32'(cntRun), 32'd0);

    ClearA_LoadB_n = 1'b1;
    repeat (30) cycle();
    clearCounts();
    Run_n = 1'b0;
    repeat (10) cycle();
    Run_n = 1'b1;
    repeat (40) cycle();
    checkOutput("glitch_no_run", 32'(cntRun), 32'd0);
    checkOutput("glitch_busy", 32'(Busy), 32'd0);

    clearCounts();
    Run_n          = 1'b0;
    ClearA_LoadB_n = 1'b0;
    repeat (30) cycle();
    checkOutput("both_load", 32'(cntLoad), 32'd1);
    checkOutput("both_no_run", 32'(cntRun), 32'd0);
    checkOutput("both_busy", 32'(Busy), 32'd0);
    Run_n          = 1'b1;
    ClearA_LoadB_n = 1'b1;
    repeat (30) cycle();

    clearCounts();
    Run_n = 1'b0;
    for (int i = 0; i < 40 && !Busy; i++) cycle();
    checkOutput("busy_start", 32'(Busy), 32'd1);
    checkOutput("busy_one_run", 32'(cntRun), 32'd1);
    ClearA_LoadB_n = 1'b0;
    repeat (25) cycle();
    checkOutput("busy_no_load", 32'(cntLoad), 32'd0);
    ClearA_LoadB_n = 1'b1;
    Done = 1'b1;
    cycle();
    Done = 1'b0;
    cycle();
    checkOutput("done_busy_low", 32'(Busy), 32'd0);
    clearCounts();
    repeat (30) cycle();
    checkOutput("waitrel_no_run", 32'(cntRun), 32'd0);
    Run_n = 1'b1;
    repeat (25) cycle();
    Run_n = 1'b0;
    repeat (25) cycle();
    checkOutput("repress_run", 32'(cntRun), 32'd1);
    checkOutput("repress_busy", 32'(Busy), 32'd1);

    applyReset(8'h3C, 1'b0, 1'b1);
    clearCounts();
    repeat (30) cycle();
    checkOutput("rst_held_run_latency", 32'(firstRun), 32'd19);
    checkOutput("rst_held_run_count", 32'(cntRun), 32'd1);

    applyStimulus(3000);
    applyReset(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    applyStimulus(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
